// File: rtl/cdc_sorter.sv
// Comparator-free LSD radix sorter: load in clk_mn, ELEMENT_NUM*(DATA_WIDTH+2) clk_mn cycles to done on clk_mj.
// No backpressure: the UM source is never stalled and SM writes are fire-and-forget.
module cdc_sorter #(
  parameter int DATA_WIDTH       = 32,
  parameter int ELEMENT_NUM      = 128,
  parameter int LOG2_ELEMENT_NUM = 7
) (
  input  logic                        clk_mj,
  input  logic                        rst,
  input  logic                        clk_mn,
  input  logic                        UM_valid,
  input  logic [DATA_WIDTH-1:0]       UM_data,
  output logic                        SM_valid,
  output logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  output logic [DATA_WIDTH-1:0]       SM_data,
  output logic                        done
);

  localparam int AW = LOG2_ELEMENT_NUM;
  localparam int CW = LOG2_ELEMENT_NUM + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] N_C      = CW'(ELEMENT_NUM);
  localparam logic [AW-1:0] LAST_IDX = AW'(ELEMENT_NUM - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [BW-1:0] ONE_B    = BW'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_OUTPUT,
    S_FINISH
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_bank0 [ELEMENT_NUM];
  logic [DATA_WIDTH-1:0] r_bank1 [ELEMENT_NUM];
  logic                  r_src_sel;
  logic [AW-1:0]         r_idx;
  logic [BW-1:0]         r_bit;
  logic [CW-1:0]         r_z;
  logic [CW-1:0]         r_zptr;
  logic [AW-1:0]         r_optr;
  logic                  r_sm_valid;
  logic [AW-1:0]         r_sm_addr;
  logic [DATA_WIDTH-1:0] r_sm_data;
  logic                  r_finish;
  logic                  r_fin_meta;
  logic                  r_fin_sync;

  logic [AW-1:0]         w_off;
  logic [AW-1:0]         w_phys;
  logic [DATA_WIDTH-1:0] w_elem;
  logic                  w_bitval;
  logic [AW-1:0]         w_dst;
  logic                  w_last;

  // Logical order of the source bank: zeros forward from 0, then ones back down from the top.
  always_comb begin
    w_off  = r_idx - r_z[AW-1:0];
    w_phys = r_idx;
    if ({1'b0, r_idx} >= r_z) begin
      w_phys = LAST_IDX - w_off;
    end
  end

  assign w_elem   = r_src_sel ? r_bank1[w_phys] : r_bank0[w_phys];
  assign w_bitval = w_elem[r_bit];
  assign w_dst    = w_bitval ? r_optr : r_zptr[AW-1:0];
  assign w_last   = (r_idx == LAST_IDX);

  // Bank contents are don't-care after reset, so they carry no reset term.
  always_ff @(posedge clk_mn) begin
    if (!rst) begin
      if (r_state == S_LOAD && UM_valid) begin
        r_bank0[r_idx] <= UM_data;
      end else if (r_state == S_SORT && r_src_sel) begin
        r_bank0[w_dst] <= w_elem;
      end
    end
  end

  always_ff @(posedge clk_mn) begin
    if (!rst && r_state == S_SORT && !r_src_sel) begin
      r_bank1[w_dst] <= w_elem;
    end
  end

  always_ff @(posedge clk_mn) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_src_sel  <= 1'b0;
      r_idx      <= '0;
      r_bit      <= '0;
      r_z        <= N_C;
      r_zptr     <= '0;
      r_optr     <= LAST_IDX;
      r_sm_valid <= 1'b0;
      r_sm_addr  <= '0;
      r_sm_data  <= '0;
      r_finish   <= 1'b0;
    end else begin
      r_sm_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (UM_valid) begin
            r_idx <= r_idx + ONE_A;
            if (w_last) begin
              r_state   <= S_SORT;
              r_z       <= N_C;
              r_zptr    <= '0;
              r_optr    <= LAST_IDX;
              r_src_sel <= 1'b0;
              r_bit     <= '0;
            end
          end
        end
        S_SORT: begin
          r_idx <= r_idx + ONE_A;
          if (w_bitval) begin
            r_optr <= r_optr - ONE_A;
          end else begin
            r_zptr <= r_zptr + ONE_C;
          end
          if (w_last) begin
            r_z       <= r_zptr + {{AW{1'b0}}, ~w_bitval};
            r_zptr    <= '0;
            r_optr    <= LAST_IDX;
            r_src_sel <= ~r_src_sel;
            if (r_bit == LAST_BIT) begin
              r_state <= S_OUTPUT;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + ONE_B;
            end
          end
        end
        S_OUTPUT: begin
          r_sm_valid <= 1'b1;
          r_sm_addr  <= r_idx;
          r_sm_data  <= w_elem;
          r_idx      <= r_idx + ONE_A;
          if (w_last) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // Raised on the edge that drops the last write, so done trails it by a full cycle at least.
          r_finish <= 1'b1;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_mj) begin
    if (rst) begin
      r_fin_meta <= 1'b0;
      r_fin_sync <= 1'b0;
    end else begin
      r_fin_meta <= r_finish;
      r_fin_sync <= r_fin_meta;
    end
  end

  assign SM_valid = r_sm_valid;
  assign SM_addr  = r_sm_addr;
  assign SM_data  = r_sm_data;
  assign done     = r_fin_sync;

endmodule

// File: tb/tb_cdc_sorter.sv
// Bench for cdc_sorter: job table plus an abort-and-restart sequence, scoreboard fed by a reference sort.
module tb_cdc_sorter;

  localparam int N  = 128;
  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk_mj;
  logic          clk_mn;
  logic          rst;
  logic          UM_valid;
  logic [DW-1:0] UM_data;
  logic          SM_valid;
  logic [AW-1:0] SM_addr;
  logic [DW-1:0] SM_data;
  logic          done;

  cdc_sorter #(.DATA_WIDTH(DW), .ELEMENT_NUM(N), .LOG2_ELEMENT_NUM(AW)) dut (
    .clk_mj   (clk_mj),
    .rst      (rst),
    .clk_mn   (clk_mn),
    .UM_valid (UM_valid),
    .UM_data  (UM_data),
    .SM_valid (SM_valid),
    .SM_addr  (SM_addr),
    .SM_data  (SM_data),
    .done     (done)
  );

  initial begin
    clk_mn = 1'b0;
    forever #5 clk_mn = ~clk_mn;
  end

  // clk_mj rises on every fourth clk_mn rising edge.
  initial begin
    clk_mj = 1'b0;
    #5;
    forever #20 clk_mj = ~clk_mj;
  end

  typedef struct {
    int            kind;
    bit            use_exp;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } job_t;

  job_t          jobs [5];
  logic [DW-1:0] words [N];
  logic [DW-1:0] model [N];
  logic [DW-1:0] sm_mem [N];
  logic [DW-1:0] exp_q [$];

  int  n_cmp;
  int  n_fail;
  int  n_writes;
  int  exp_addr;
  int  done_rises;
  bit  prev_done;
  time last_wr_time;
  time done_time;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Sink side: SM_* captured on the falling clk_mn edge.
  always @(negedge clk_mn) begin
    if (!rst) begin
      if (SM_valid) begin
        chk("sm_addr", 32'(SM_addr), 32'(exp_addr));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sm_unexpected_write: got addr %0d data %h, required no write", SM_addr, SM_data);
        end else begin
          chk("sm_data", SM_data, exp_q.pop_front());
        end
        sm_mem[SM_addr] = SM_data;
        exp_addr++;
        n_writes++;
        last_wr_time = $time;
      end
      if (done && !prev_done) begin
        done_rises++;
        done_time = $time;
        chk("writes_before_done", 32'(n_writes), 32'(N));
      end
      prev_done = done;
    end
  end

  task automatic apply_reset();
    @(negedge clk_mn);
    rst      = 1'b1;
    UM_valid = 1'b0;
    UM_data  = '0;
    repeat (3) @(posedge clk_mj);
    @(negedge clk_mn);
    chk("rst_sm_valid", 32'(SM_valid), 32'd0);
    chk("rst_sm_addr", 32'(SM_addr), 32'd0);
    chk("rst_sm_data", SM_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    exp_q.delete();
    n_writes     = 0;
    exp_addr     = 0;
    done_rises   = 0;
    prev_done    = 1'b0;
    last_wr_time = 0;
    done_time    = 0;
    for (int k = 0; k < N; k++) sm_mem[k] = 'x;
    rst = 1'b0;
  endtask

  task automatic gen_words(input int kind);
    logic [DW-1:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       words[i] = $urandom();
        1:       words[i] = 32'hDEAD_BEEF;
        2:       words[i] = 32'(i);
        3:       words[i] = 32'(N - 1 - i);
        default: words[i] = (i < 8) ? corner[i % 4] : corner[$urandom_range(0, 3)];
      endcase
    end
  endtask

  // Reference: insertion sort, then the whole result queued for the scoreboard.
  task automatic build_model();
    logic [DW-1:0] key;
    int j;
    for (int i = 0; i < N; i++) model[i] = words[i];
    for (int i = 1; i < N; i++) begin
      key = model[i];
      j = i - 1;
      while (j >= 0 && model[j] > key) begin
        model[j + 1] = model[j];
        j--;
      end
      model[j + 1] = key;
    end
    for (int i = 0; i < N; i++) exp_q.push_back(model[i]);
  endtask

  // Idle cycles first, then the job, then trailing words that must be ignored.
  task automatic stream_words();
    repeat (5) @(negedge clk_mn);
    for (int i = 0; i < N; i++) begin
      @(negedge clk_mn);
      UM_valid = 1'b1;
      UM_data  = words[i];
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_mn);
      UM_valid = 1'b1;
      UM_data  = 32'h5555_5555;
    end
    @(negedge clk_mn);
    UM_valid = 1'b0;
    UM_data  = '0;
  endtask

  task automatic finish_job(input bit use_exp, input logic [DW-1:0] ef, input logic [DW-1:0] el);
    int cyc;
    cyc = 0;
    while (!done && cyc < 10000) begin
      @(posedge clk_mj);
      cyc++;
    end
    repeat (2) @(negedge clk_mn);
    #1;
    chk("done_within_bound", 32'(done), 32'd1);
    chk("write_count", 32'(n_writes), 32'(N));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("done_after_last_write", 32'(done_time >= last_wr_time + 10), 32'd1);
    if (use_exp) begin
      chk("sm_first", sm_mem[0], ef);
      chk("sm_last", sm_mem[N-1], el);
    end
    repeat (20) @(posedge clk_mj);
    @(negedge clk_mn);
    chk("done_held", 32'(done), 32'd1);
    chk("done_rises_once", 32'(done_rises), 32'd1);
    chk("no_late_writes", 32'(n_writes), 32'(N));
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    UM_valid = 1'b0;
    UM_data  = '0;

    jobs[0] = '{kind: 0, use_exp: 1'b0, exp_first: 32'h0,         exp_last: 32'h0};
    jobs[1] = '{kind: 1, use_exp: 1'b1, exp_first: 32'hDEADBEEF,  exp_last: 32'hDEADBEEF};
    jobs[2] = '{kind: 2, use_exp: 1'b1, exp_first: 32'd0,         exp_last: 32'd127};
    jobs[3] = '{kind: 3, use_exp: 1'b1, exp_first: 32'd0,         exp_last: 32'd127};
    jobs[4] = '{kind: 4, use_exp: 1'b1, exp_first: 32'h0,         exp_last: 32'hFFFFFFFF};

    for (int t = 0; t < 5; t++) begin
      apply_reset();
      gen_words(jobs[t].kind);
      build_model();
      stream_words();
      finish_job(jobs[t].use_exp, jobs[t].exp_first, jobs[t].exp_last);
    end

    // Abort during SORT, then a fresh job must complete on its own data.
    apply_reset();
    gen_words(0);
    build_model();
    stream_words();
    repeat (300) @(negedge clk_mn);
    chk("abort_no_write_in_sort", 32'(n_writes), 32'd0);
    chk("abort_done_low", 32'(done), 32'd0);
    apply_reset();
    gen_words(0);
    build_model();
    stream_words();
    finish_job(1'b0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
